// File: rtl/rv_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch and register read for rv_decode_stage.
// The slave modport is the decode stage; master is the fetch/consumer side.
interface rv_decode_stage_if #(
  parameter int unsigned PC_W = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     in_data_i;
  logic [PC_W-1:0] in_pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [PC_W-1:0] out_pc_o;
  logic [6:0]      out_opcode_o;
  logic [2:0]      out_funct3_o;
  logic [6:0]      out_funct7_o;
  logic [4:0]      out_rd_o;
  logic [4:0]      out_rs1_o;
  logic [4:0]      out_rs2_o;
  logic [2:0]      out_fmt_o;
  logic [31:0]     out_imm_o;
  logic            out_illegal_o;

  modport slave (
    input  in_valid_i, in_data_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_opcode_o, out_funct3_o, out_funct7_o,
           out_rd_o, out_rs1_o, out_rs2_o, out_fmt_o, out_imm_o, out_illegal_o
  );

  modport master (
    output in_valid_i, in_data_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_opcode_o, out_funct3_o, out_funct7_o,
           out_rd_o, out_rs1_o, out_rs2_o, out_fmt_o, out_imm_o, out_illegal_o
  );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: field split, immediate select, two-entry elastic output buffer.
// Define RV_DECODE_ILLEGAL_CHECK_EN to build the illegal-instruction checker.
module rv_decode_stage #(
  parameter int unsigned PC_W       = 32,
  parameter bit          SWAP_BYTES = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic              flush_i,
  rv_decode_stage_if.slave bus
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcSystem = 7'b1110011;
  localparam logic [6:0] OpcFence  = 7'b0001111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;
  localparam logic [2:0] FmtX = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      fmt;
    logic [31:0]     imm;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e      state_q, state_d;
  bundle_t     out_q, out_d, skid_q, skid_d, dec;
  logic [31:0] instr;
  logic        acc, pop;

  // Combinational decode of the incoming word
  always_comb begin
    instr      = SWAP_BYTES ? {bus.in_data_i[7:0], bus.in_data_i[15:8],
                               bus.in_data_i[23:16], bus.in_data_i[31:24]}
                            : bus.in_data_i;
    dec        = '0;
    dec.pc     = bus.in_pc_i;
    dec.opcode = instr[6:0];
    dec.funct3 = instr[14:12];
    dec.funct7 = instr[31:25];
    dec.rd     = instr[11:7];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];

    case (instr[6:0])
      OpcOp:                                              dec.fmt = FmtR;
      OpcOpImm, OpcLoad, OpcJalr, OpcSystem, OpcFence:    dec.fmt = FmtI;
      OpcStore:                                           dec.fmt = FmtS;
      OpcBranch:                                          dec.fmt = FmtB;
      OpcLui, OpcAuipc:                                   dec.fmt = FmtU;
      OpcJal:                                             dec.fmt = FmtJ;
      default:                                            dec.fmt = FmtX;
    endcase

    case (dec.fmt)
      FmtI:    dec.imm = {{20{instr[31]}}, instr[31:20]};
      FmtS:    dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FmtB:    dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FmtU:    dec.imm = {instr[31:12], 12'b0};
      FmtJ:    dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: dec.imm = '0;
    endcase

`ifdef RV_DECODE_ILLEGAL_CHECK_EN
    dec.illegal = (instr[1:0] != 2'b11) || (dec.fmt == FmtX);
    case (instr[6:0])
      OpcBranch: if (dec.funct3 inside {3'b010, 3'b011}) dec.illegal = 1'b1;
      OpcLoad:   if (dec.funct3 inside {3'b011, 3'b110, 3'b111}) dec.illegal = 1'b1;
      OpcStore:  if (dec.funct3 >= 3'b011) dec.illegal = 1'b1;
      OpcJalr:   if (dec.funct3 != 3'b000) dec.illegal = 1'b1;
      OpcOp: begin
        if (!(dec.funct7 inside {7'b0000000, 7'b0100000})) dec.illegal = 1'b1;
        if (dec.funct7 == 7'b0100000 && !(dec.funct3 inside {3'b000, 3'b101}))
          dec.illegal = 1'b1;
      end
      OpcOpImm: begin
        if (dec.funct3 == 3'b001 && dec.funct7 != 7'b0000000) dec.illegal = 1'b1;
        if (dec.funct3 == 3'b101 && !(dec.funct7 inside {7'b0000000, 7'b0100000}))
          dec.illegal = 1'b1;
      end
      default: ;
    endcase
`else
    dec.illegal = 1'b0;
`endif
  end

  // Ready depends only on registered state, never on out_ready_i
  assign bus.in_ready_o  = ~rst_i & (state_q != StTwo);
  assign bus.out_valid_o = (state_q != StEmpty);
  assign acc = bus.in_valid_i & bus.in_ready_o;
  assign pop = bus.out_valid_o & bus.out_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (acc) begin
          state_d = StOne;
          out_d   = dec;
        end
        StOne: begin
          if (acc && !pop) begin
            state_d = StTwo;
            skid_d  = dec;
          end else if (acc && pop) begin
            out_d = dec;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: if (pop) begin
          state_d = StOne;
          out_d   = skid_q;
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.out_pc_o      = out_q.pc;
  assign bus.out_opcode_o  = out_q.opcode;
  assign bus.out_funct3_o  = out_q.funct3;
  assign bus.out_funct7_o  = out_q.funct7;
  assign bus.out_rd_o      = out_q.rd;
  assign bus.out_rs1_o     = out_q.rs1;
  assign bus.out_rs2_o     = out_q.rs2;
  assign bus.out_fmt_o     = out_q.fmt;
  assign bus.out_imm_o     = out_q.imm;
  assign bus.out_illegal_o = out_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed scoreboard bench for rv_decode_stage (SWAP_BYTES=1, fetch words byte-swapped here).
module tb_rv_decode_stage;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  rv_decode_stage_if #(.PC_W(32)) bus ();

  rv_decode_stage #(.PC_W(32), .SWAP_BYTES(1'b1)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  localparam int N = 14;
  logic [31:0] t_instr [N] = '{32'h00500093, 32'hFE000EE3, 32'h123452B7, 32'h0020A423,
                               32'hFE20AE23, 32'h0010006F, 32'hFFDFF0EF, 32'hFFFFF117,
                               32'hFFC12083, 32'h4030D093, 32'h00000033, 32'h40001033,
                               32'h00000000, 32'h00002063};
  logic [2:0]  t_fmt   [N] = '{3'd1, 3'd3, 3'd4, 3'd2, 3'd2, 3'd5, 3'd5, 3'd4,
                               3'd1, 3'd1, 3'd0, 3'd0, 3'd7, 3'd3};
  logic [31:0] t_imm   [N] = '{32'h00000005, 32'hFFFFFFFC, 32'h12345000, 32'h00000008,
                               32'hFFFFFFFC, 32'h00000800, 32'hFFFFFFFC, 32'hFFFFF000,
                               32'hFFFFFFFC, 32'h00000403, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        t_ill   [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  exp_t sb[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   n_pop   = 0;
  logic last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Present table entry idx at the given PC and remember its expected decode
  task automatic offer(input int idx, input logic [31:0] pc);
    cur.pc    = pc;
    cur.instr = t_instr[idx];
    cur.fmt   = t_fmt[idx];
    cur.imm   = t_imm[idx];
`ifdef RV_DECODE_ILLEGAL_CHECK_EN
    cur.ill   = t_ill[idx];
`else
    cur.ill   = 1'b0;
`endif
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = swap32(t_instr[idx]);
    bus.in_pc_i    = pc;
  endtask

  // One clock: monitor handshakes at negedge, then advance past the rising edge
  task automatic step();
    logic acc, pop;
    exp_t e;
    @(negedge clk);
    acc      = bus.in_valid_i & bus.in_ready_o;
    pop      = bus.out_valid_o & bus.out_ready_i;
    last_acc = acc & ~rst & ~flush;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (pop) begin
        n_pop++;
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(bus.out_pc_o), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("pc", 64'(bus.out_pc_o), 64'(e.pc));
          chk("fmt", 64'(bus.out_fmt_o), 64'(e.fmt));
          chk("imm", 64'(bus.out_imm_o), 64'(e.imm));
          chk("illegal", 64'(bus.out_illegal_o), 64'(e.ill));
          chk("fields", 64'({bus.out_opcode_o, bus.out_funct3_o, bus.out_funct7_o,
                             bus.out_rd_o, bus.out_rs1_o, bus.out_rs2_o}),
              64'({e.instr[6:0], e.instr[14:12], e.instr[31:25], e.instr[11:7],
                   e.instr[19:15], e.instr[24:20]}));
        end
      end
      if (acc) begin
        n_acc++;
        sb.push_back(cur);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, acc0, pop0;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.in_pc_i = '0; bus.out_ready_i = 1'b0;
    step(); step();
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_outputs", 64'({bus.out_pc_o, bus.out_imm_o}), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(bus.in_ready_o), 64'd1);

    // Latency: ADDI accepted in cycle N is valid in N+1
    bus.out_ready_i = 1'b1;
    offer(0, 32'h100);
    step();
    bus.in_valid_i = 1'b0;
    chk("latency_valid", 64'(bus.out_valid_o), 64'd1);
    chk("latency_rd", 64'(bus.out_rd_o), 64'd1);
    step();

    // Full-rate stream over the whole vector table
    for (int i = 0; i < N; i++) begin
      offer(i, 32'h200 + 32'(i * 4));
      chk("stream_ready", 64'(bus.in_ready_o), 64'd1);
      step();
    end
    bus.in_valid_i = 1'b0;
    step(); step();
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // Back-pressure: two words absorbed, then ready drops
    bus.out_ready_i = 1'b0;
    acc0 = n_acc; pop0 = n_pop; idx = 0;
    offer(0, 32'h0);  step();
    offer(1, 32'h4);
    chk("bp_ready_one", 64'(bus.in_ready_o), 64'd1);
    step();
    chk("bp_ready_drop", 64'(bus.in_ready_o), 64'd0);
    offer(2, 32'h8);  step(); step();
    chk("bp_absorbed", 64'(n_acc - acc0), 64'd2);
    chk("bp_still_stalled", 64'(bus.in_ready_o), 64'd0);
    bus.out_ready_i = 1'b1;
    idx = 2;
    for (int c = 0; c < 20 && (idx < 4 || sb.size() != 0); c++) begin
      if (idx < 4) offer(idx, 32'(idx * 4));
      else bus.in_valid_i = 1'b0;
      step();
      if (last_acc) idx++;
    end
    bus.in_valid_i = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd4);
    chk("bp_all_popped", 64'(n_pop - pop0), 64'd4);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Flush while TWO with a word offered
    bus.out_ready_i = 1'b0;
    offer(3, 32'h300); step();
    offer(4, 32'h304); step();
    chk("fl_state_two", 64'(bus.in_ready_o), 64'd0);
    flush = 1'b1;
    offer(5, 32'h308); step();
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("fl_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready_o), 64'd1);
    bus.out_ready_i = 1'b1;
    step(); step(); step();

    // One-cycle reset mid-stream
    bus.out_ready_i = 1'b0;
    offer(6, 32'h400); step();
    rst = 1'b1;
    offer(7, 32'h404); step();
    chk("mrst_in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("mrst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("mrst_fields", 64'({bus.out_pc_o, bus.out_fmt_o, bus.out_rd_o, bus.out_illegal_o}),
        64'd0);
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
    #1;
    chk("mrst_ready_after", 64'(bus.in_ready_o), 64'd1);
    bus.out_ready_i = 1'b1;
    step(); step();
    chk("mrst_no_output", 64'(bus.out_valid_o), 64'd0);

    // Post-reset sanity: one word still decodes correctly
    offer(11, 32'h500); step();
    bus.in_valid_i = 1'b0;
    step(); step();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Parametrised RV32I decode stage between the fetch/memory interface and register read. Accepts raw fetched words with an optional byte swap and splits the fields. Selects and sign-extends the one immediate matching the instruction format, then presents the result through an elastic two-entry valid/ready buffer. It sustains one instruction per cycle under back-pressure and supports a pipeline flush.

## Interface
- `PC_W`, 32: width of the program counter carried alongside each instruction.
- `SWAP_BYTES`, 1: 1 reverses byte order of `in_data_i` (little-endian memory word to instruction); 0 passes it through unchanged.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `flush_i`  in  1  drop all buffered instructions this cycle.
- `in_valid_i`  in  1  fetch word valid.
- `in_ready_o`  out  1  stage can accept a word.
- `in_data_i`  in  32  raw fetched word.
- `in_pc_i`  in  PC_W  PC of the word.
- `out_valid_o`  out  1  decoded instruction valid.
- `out_ready_i`  in  1  downstream accepts.
- `out_pc_o`  out  PC_W  PC of the decoded instruction.
- `out_opcode_o`  out  7  instr[6:0].
- `out_funct3_o`  out  3  instr[14:12].
- `out_funct7_o`  out  7  instr[31:25].
- `out_rd_o`, `out_rs1_o`, `out_rs2_o`  out  5 each  instr[11:7], [19:15], [24:20].
- `out_fmt_o`  out  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=unknown.
- `out_imm_o`  out  32  sign-extended immediate for `out_fmt_o`; 0 for R or unknown.
- `out_illegal_o`  out  1  instruction not legal RV32I (see Configuration).

## Operation
- Byte swap: with SWAP_BYTES=1, instr = {d[7:0], d[15:8], d[23:16], d[31:24]}.
- Format by opcode:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - any other opcode → 7
- Immediates per RV32I:
  - I = sext(i[31:20])
  - S = sext({i[31:25], i[11:7]})
  - B = sext({i[31], i[7], i[30:25], i[11:8], 1'b0})
  - U = {i[31:12], 12'b0}
  - J = sext({i[31], i[19:12], i[20], i[30:21], 1'b0})
- Decode is combinational on the input word. The decoded bundle, including the PC, is what gets buffered.
- Buffer: output register (OUT) plus skid register (SKID). States:
  - EMPTY: OUT and SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - TWO: both valid.
- Transitions (acc = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i):
  - EMPTY --acc→ ONE.
  - ONE --acc & !pop→ TWO (new bundle to SKID).
  - ONE --!acc & pop→ EMPTY.
  - ONE --acc & pop→ ONE (new bundle to OUT).
  - TWO --pop→ ONE (SKID moves to OUT). No accept is possible in TWO.
- `in_ready_o` = 1 in EMPTY and ONE, 0 in TWO. It is a registered state decode with no combinational path from `out_ready_i`.
- `flush_i` has priority over all transitions: next state is EMPTY and the same-cycle input is discarded.
- Output fields hold their value while `out_valid_o`=0. Bench must not check them then.

## Timing
- Latency: a word accepted in cycle N appears on `out_valid_o` in cycle N+1.
- Throughput: 1 instruction/cycle with `out_ready_i` held high.
- Stall: with `out_ready_i`=0, two words are absorbed, then `in_ready_o` drops the following cycle. Order is preserved.
- Reset: during `rst_i`, `in_ready_o`=0. All other outputs reset to 0, state resets to EMPTY. `in_ready_o`=1 in the first cycle after release.
- Reset or flush mid-stream: buffered entries are lost and never presented. A word offered in the same cycle is not accepted.

## Configuration
- `RV_DECODE_ILLEGAL_CHECK_EN` defined: `out_illegal_o`=1 when any of the following holds:
  - i[1:0]≠11.
  - `out_fmt_o`=7.
  - Branch with funct3 010/011.
  - Load with funct3 011/110/111.
  - Store with funct3 ≥011.
  - JALR with funct3≠000.
  - OP with funct7∉{0000000, 0100000}.
  - OP with funct7=0100000 and funct3∉{000, 101}.
  - OP-IMM shift (funct3 001) with funct7≠0.
  - OP-IMM shift (funct3 101) with funct7∉{0000000, 0100000}.
- Not defined: `out_illegal_o` tied to 0. No check logic is synthesised.

## Test plan
- ADDI x1,x0,5, `in_data_i`=0x93005000, SWAP_BYTES=1 → next cycle: `out_valid_o`=1, `out_fmt_o`=1, `out_rd_o`=1, `out_rs1_o`=0, `out_imm_o`=0x00000005, `out_illegal_o`=0.
- BEQ x0,x0,-4 (instr 0xFE000EE3, SWAP_BYTES=0) → `out_fmt_o`=3, `out_imm_o`=0xFFFFFFFC. LUI x5,0x12345 (0x123452B7) → `out_fmt_o`=4, `out_rd_o`=5, `out_imm_o`=0x12345000.
- Back-pressure: stream 4 words (PC 0,4,8,C) with `out_ready_i`=0 → words PC 0 and 4 accepted, `in_ready_o`=0 from the cycle after the second accept. Release `out_ready_i` → outputs PC 0,4,8,C in order, no loss or duplication.
- Flush in state TWO with `in_valid_i`=1 → next cycle `out_valid_o`=0 and `in_ready_o`=1. The flushed and offered words never appear.
- Reset asserted mid-stream for 1 cycle → all outputs 0 and `in_ready_o`=0 during reset; EMPTY afterwards.
- With `RV_DECODE_ILLEGAL_CHECK_EN`: 0x00000000 → `out_illegal_o`=1. SUB with funct3 001 (0x40001033) → 1. ADD (0x00000033) → 0. Without the macro, all three → 0.
